// File: rtl/oq_pkt_scheduler.sv
// Round-robin output-queue read scheduler: grants one queue with a complete packet,
// issues its word count of read strobes under downstream backpressure, then retires it.
module oq_pkt_scheduler #(
    parameter int NUM_OUTPUT_QUEUES  = 8,
    parameter int NUM_OQ_WIDTH       = 3,
    parameter int PKT_WORD_CNT_WIDTH = 8
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic                                            enable,
    input  logic [NUM_OUTPUT_QUEUES-1:0]                    oq_pkt_avail,
    input  logic [NUM_OUTPUT_QUEUES*PKT_WORD_CNT_WIDTH-1:0] oq_pkt_word_len,
    input  logic                                            out_rdy,
    output logic [NUM_OUTPUT_QUEUES-1:0]                    oq_rd_en,
    output logic [NUM_OUTPUT_QUEUES-1:0]                    oq_pkt_done,
    output logic                                            out_wr,
    output logic [NUM_OQ_WIDTH-1:0]                         out_sel,
    output logic                                            out_eop,
    output logic                                            busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int N = NUM_OUTPUT_QUEUES;
    localparam int W = PKT_WORD_CNT_WIDTH;

    logic [1:0]              state_q, state_d;
    logic [W-1:0]            word_cnt_q, word_cnt_d;
    logic [NUM_OQ_WIDTH-1:0] out_sel_q, out_sel_d;
    logic [NUM_OQ_WIDTH-1:0] last_grant_q, last_grant_d;
    logic                    out_wr_q, out_eop_q;

    logic                    grant_found;
    logic [NUM_OQ_WIDTH-1:0] grant_idx;
    logic [W-1:0]            head_len;
    logic [N-1:0]            sel_onehot;
    logic                    rd;
    int                      idx;

    // Rotating priority search starting just after the last retired queue.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(last_grant_q) + 1 + i) % N;
            if (!grant_found && oq_pkt_avail[idx]) begin
                grant_found = 1'b1;
                grant_idx   = NUM_OQ_WIDTH'(idx);
            end
        end
    end

    assign head_len   = oq_pkt_word_len[int'(grant_idx)*W +: W];
    assign sel_onehot = {{(N-1){1'b0}}, 1'b1} << out_sel_q;
    assign rd         = (state_q == ST_XFER) && out_rdy;

    assign oq_rd_en    = rd ? sel_onehot : '0;
    assign oq_pkt_done = (state_q == ST_DONE) ? sel_onehot : '0;
    assign busy        = (state_q != ST_IDLE);
    assign out_wr      = out_wr_q;
    assign out_eop     = out_eop_q;
    assign out_sel     = out_sel_q;

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        out_sel_d    = out_sel_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && grant_found) begin
                    out_sel_d  = grant_idx;
                    // A zero-length head still moves one word so the queue can advance.
                    word_cnt_d = (head_len == '0) ? W'(1) : head_len;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                if (rd) begin
                    word_cnt_d = word_cnt_q - W'(1);
                    if (word_cnt_q == W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                last_grant_d = out_sel_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            out_sel_q    <= '0;
            last_grant_q <= NUM_OQ_WIDTH'(N - 1);
            out_wr_q     <= 1'b0;
            out_eop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            out_sel_q    <= out_sel_d;
            last_grant_q <= last_grant_d;
            out_wr_q     <= rd;
            out_eop_q    <= rd && (word_cnt_q == W'(1));
        end
    end

endmodule

// File: tb/tb_oq_pkt_scheduler.sv
// Directed bench for oq_pkt_scheduler; a scoreboard holds the expected {eop, sel}
// of every downstream word and is drained as out_wr appears.
module tb_oq_pkt_scheduler;

    localparam int N  = 8;
    localparam int QW = 3;
    localparam int W  = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           enable;
    logic [N-1:0]   oq_pkt_avail;
    logic [N*W-1:0] oq_pkt_word_len;
    logic           out_rdy;
    logic [N-1:0]   oq_rd_en;
    logic [N-1:0]   oq_pkt_done;
    logic           out_wr;
    logic [QW-1:0]  out_sel;
    logic           out_eop;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [3:0] sb_q[$];

    oq_pkt_scheduler #(.NUM_OUTPUT_QUEUES(N), .NUM_OQ_WIDTH(QW), .PKT_WORD_CNT_WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .oq_pkt_avail(oq_pkt_avail),
        .oq_pkt_word_len(oq_pkt_word_len), .out_rdy(out_rdy), .oq_rd_en(oq_rd_en),
        .oq_pkt_done(oq_pkt_done), .out_wr(out_wr), .out_sel(out_sel), .out_eop(out_eop),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Downstream side: every out_wr must match the next expected word.
    always @(negedge clk) begin
        if (reset_n && out_wr) begin
            if (sb_q.size() == 0) chk("sb_unexpected_wr", 0, 1);
            else begin
                logic [3:0] e;
                e = sb_q.pop_front();
                chk("sb_sel", {29'd0, out_sel}, {29'd0, e[2:0]});
                chk("sb_eop", {31'd0, out_eop}, {31'd0, e[3]});
            end
        end
    end

    task automatic push_pkt(input int q, input int len);
        int n;
        n = (len == 0) ? 1 : len;
        for (int k = 1; k <= n; k++) sb_q.push_back({(k == n), q[2:0]});
    endtask

    task automatic set_len(input int q, input int len);
        oq_pkt_word_len[q*W +: W] = len[W-1:0];
    endtask

    // Observe one packet on queue q until its done pulse; checks read count,
    // that reads only happen with out_rdy high, and (unthrottled) that reads are back-to-back.
    task automatic xfer(input int q, input int words, input bit toggle, input bit kill_en);
        int reads, first, last;
        bit seen_done;
        logic [N-1:0] qmask;
        qmask = N'(1) << q;
        reads = 0; first = 0; last = 0; seen_done = 0;
        for (int t = 0; t < 200 && !seen_done; t++) begin
            @(negedge clk);
            if (oq_pkt_done != '0) begin
                seen_done = 1;
                chk("done_onehot", {24'd0, oq_pkt_done}, {24'd0, qmask});
            end else if (oq_rd_en != '0) begin
                if (reads == 0) first = cyc;
                last = cyc;
                reads++;
                if (oq_rd_en !== qmask) chk("rd_queue", {24'd0, oq_rd_en}, {24'd0, qmask});
                if (out_rdy !== 1'b1) chk("rd_without_rdy", {31'd0, out_rdy}, 1);
                if (kill_en && reads == 1) begin
                    @(posedge clk); #1;
                    enable = 1'b0;
                    oq_pkt_avail = 8'h03;
                end
            end
            if (toggle && !seen_done) begin
                @(posedge clk); #1;
                out_rdy = ~out_rdy;
            end
        end
        if (!seen_done) chk("done_timeout", 0, 1);
        chk("read_count", reads, words);
        if (!toggle) chk("back_to_back", last - first + 1, words);
        out_rdy = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {7'd0, oq_rd_en, oq_pkt_done, out_wr, out_eop, busy, out_sel},
            32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int prev_c;
        reset_n = 1'b0; enable = 1'b0; oq_pkt_avail = '0; oq_pkt_word_len = '0; out_rdy = 1'b0;
        do_reset();

        // 4-word packet on queue 0, unthrottled.
        @(posedge clk); #1;
        enable = 1'b1; out_rdy = 1'b1; set_len(0, 4); oq_pkt_avail = 8'h01;
        push_pkt(0, 4);
        xfer(0, 4, 0, 0);
        @(posedge clk); #1;
        oq_pkt_avail = '0;
        @(negedge clk);
        chk("t1_idle_after", {31'd0, busy}, 0);

        // All queues ready with 1-word packets: strict rotation, 3 cycles apart.
        do_reset();
        @(posedge clk); #1;
        enable = 1'b1; out_rdy = 1'b1;
        for (int q = 0; q < N; q++) set_len(q, 1);
        oq_pkt_avail = 8'hFF;
        for (int i = 0; i < 9; i++) push_pkt(i % N, 1);
        prev_c = 0;
        for (int i = 0; i < 9; i++) begin
            int t;
            t = 0;
            @(negedge clk);
            while (oq_rd_en == '0 && t < 20) begin @(negedge clk); t++; end
            chk("rr_grant", {24'd0, oq_rd_en}, {24'd0, 8'(1 << (i % N))});
            if (i > 0) chk("rr_spacing", cyc - prev_c, 3);
            prev_c = cyc;
            if (i == 8) begin @(posedge clk); #1; oq_pkt_avail = '0; end
        end
        repeat (4) @(negedge clk);
        chk("rr_sb_drained", sb_q.size(), 0);

        // Throttled 5-word packet on queue 2.
        @(posedge clk); #1;
        set_len(2, 5); oq_pkt_avail = 8'h04;
        push_pkt(2, 5);
        xfer(2, 5, 1, 0);
        @(posedge clk); #1;
        oq_pkt_avail = '0;

        // Zero length on queue 3 reads one word.
        @(posedge clk); #1;
        set_len(3, 0); oq_pkt_avail = 8'h08;
        push_pkt(3, 0);
        xfer(3, 1, 0, 0);
        @(posedge clk); #1;
        oq_pkt_avail = '0;

        // enable drops mid-packet on queue 1: packet completes, no further grant.
        @(posedge clk); #1;
        set_len(1, 6); set_len(0, 2); oq_pkt_avail = 8'h02;
        push_pkt(1, 6);
        xfer(1, 6, 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("en_low_idle", {23'd0, busy, oq_rd_en}, 32'd0);
        end
        @(posedge clk); #1;
        enable = 1'b1;
        push_pkt(0, 2);
        xfer(0, 2, 0, 0);
        @(posedge clk); #1;
        oq_pkt_avail = '0;

        // Reset after 2 of 8 reads on queue 5, then lowest ready queue wins.
        @(posedge clk); #1;
        set_len(5, 8); oq_pkt_avail = 8'h20;
        push_pkt(5, 8);
        begin
            int reads, t;
            reads = 0; t = 0;
            while (reads < 2 && t < 50) begin
                @(negedge clk);
                if (oq_rd_en != '0) reads++;
                t++;
            end
            chk("pre_reset_reads", reads, 2);
        end
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outs", {7'd0, oq_rd_en, oq_pkt_done, out_wr, out_eop, busy, out_sel},
            32'd0);
        sb_q.delete();
        set_len(3, 2); oq_pkt_avail = 8'h28;
        @(posedge clk); #1;
        reset_n = 1'b1;
        push_pkt(3, 2);
        xfer(3, 2, 0, 0);
        @(posedge clk); #1;
        oq_pkt_avail = '0;
        repeat (4) @(negedge clk);
        chk("final_sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
